// File: rtl/hockey_arena.sv
// hockey_arena -- two-player electronic air-hockey game core.
//
// Sits between debounced player inputs and the display/score driver.
// Buttons act only on their rising edge (a held button counts once).
// A served or returned puck travels one column per step, reflecting off
// the top and bottom walls on diagonal shots. The receiving player must
// press within a response window with the paddle on the puck's row, or
// the other player scores. A goal is flashed for a hold period, then the
// conceding player serves, or the game ends once a score hits WIN_SCORE.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-low reset
//   BTN_A/B     hit/serve buttons
//   DIR_A/B     shot direction: 00 straight, 01 up (Y+1), 10 down (Y-1),
//               11 treated as straight
//   Y_in_A/B    paddle rows
//   X_COORD     puck column (A goal line = 0, B goal line = X_LAST)
//   Y_COORD     puck row (0..Y_LAST)
//   SCORE_A/B   player scores, saturating at WIN_SCORE
//   GOAL_FLASH  high while a goal is being displayed
//   GAME_OVER   high once a player has won
//   STATE       FSM state for debug:
//               0 IDLE, 1 SERVE_A, 2 SERVE_B, 3 MOVE_A, 4 MOVE_B,
//               5 RESP_A, 6 RESP_B, 7 GOAL_A, 8 GOAL_B, 9 OVER
//
// Build option:
//   HOCKEY_SPEEDUP_EN  when defined, every successful return shortens the
//                      step period by one cycle (floor 1); the period goes
//                      back to STEP_CYC on every goal and on reset.
//                      When undefined the step period is always STEP_CYC.

module hockey_arena #(
  parameter int XW        = 3,
  parameter int YW        = 3,
  parameter int X_LAST    = 4,
  parameter int Y_LAST    = 4,
  parameter int SCORE_W   = 3,
  parameter int WIN_SCORE = 3,
  parameter int STEP_CYC  = 1,
  parameter int RESP_CYC  = 8,
  parameter int HOLD_CYC  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               BTN_A,
  input  logic               BTN_B,
  input  logic [1:0]         DIR_A,
  input  logic [1:0]         DIR_B,
  input  logic [YW-1:0]      Y_in_A,
  input  logic [YW-1:0]      Y_in_B,
  output logic [XW-1:0]      X_COORD,
  output logic [YW-1:0]      Y_COORD,
  output logic [SCORE_W-1:0] SCORE_A,
  output logic [SCORE_W-1:0] SCORE_B,
  output logic               GOAL_FLASH,
  output logic               GAME_OVER,
  output logic [3:0]         STATE
);

  // Counter widths: the step counter and period hold values up to
  // STEP_CYC, the response and hold counters up to their window length.
  localparam int PW = (STEP_CYC > 1) ? $clog2(STEP_CYC + 1) : 1;
  localparam int RW = (RESP_CYC > 1) ? $clog2(RESP_CYC + 1) : 1;
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC + 1) : 1;

  localparam logic [PW-1:0]      STEP_P    = PW'(STEP_CYC);
  localparam logic [PW-1:0]      ONE_P     = PW'(1);
  localparam logic [RW-1:0]      RESP_LAST = RW'(RESP_CYC - 1);
  localparam logic [HW-1:0]      HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [XW-1:0]      X_END     = XW'(X_LAST);
  localparam logic [XW-1:0]      X_PRE     = XW'(X_LAST - 1);
  localparam logic [XW-1:0]      X_ONE     = XW'(1);
  localparam logic [YW-1:0]      Y_TOP     = YW'(Y_LAST);
  localparam logic [YW-1:0]      Y_BELOW   = YW'(Y_LAST - 1);
  localparam logic [YW-1:0]      Y_ONE     = YW'(1);
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SC_ONE    = SCORE_W'(1);

  localparam logic [1:0] D_STR = 2'b00;
  localparam logic [1:0] D_UP  = 2'b01;
  localparam logic [1:0] D_DN  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SERVE_A = 4'd1,
    S_SERVE_B = 4'd2,
    S_MOVE_A  = 4'd3,
    S_MOVE_B  = 4'd4,
    S_RESP_A  = 4'd5,
    S_RESP_B  = 4'd6,
    S_GOAL_A  = 4'd7,
    S_GOAL_B  = 4'd8,
    S_OVER    = 4'd9
  } state_t;

  // Direction code 11 behaves exactly like straight, so it is folded to 00
  // at latch time and the step logic only ever sees three codes.
  function automatic logic [1:0] norm_dir(input logic [1:0] d);
    return (d == 2'b11) ? D_STR : d;
  endfunction

  state_t               state_q, state_d;
  logic                 btn_a_q, btn_b_q;
  logic                 edge_a, edge_b;
  logic [XW-1:0]        x_q, x_d;
  logic [YW-1:0]        y_q, y_d;
  logic [1:0]           dir_q, dir_d;
  logic [PW-1:0]        step_q, step_d;
  logic [PW-1:0]        period_q, period_d;
  logic [RW-1:0]        resp_q, resp_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [SCORE_W-1:0]   sa_q, sa_d, sb_q, sb_d;
  logic [YW-1:0]        y_step;
  logic [1:0]           dir_step;
  logic                 step_due;

  // Rising-edge detect: a press counts on the cycle it is first seen high.
  assign edge_a = BTN_A & ~btn_a_q;
  assign edge_b = BTN_B & ~btn_b_q;

  // A step is taken on the last cycle of the current step period.
  assign step_due = (step_q == (period_q - ONE_P));

  // Row after one step, with wall reflection: a puck moving up from the
  // top row bounces to the row below it and turns downward (and vice versa
  // at row 0), so the puck never leaves 0..Y_LAST.
  always_comb begin
    y_step   = y_q;
    dir_step = dir_q;
    case (dir_q)
      D_UP: begin
        if (y_q == Y_TOP) begin
          y_step   = Y_BELOW;
          dir_step = D_DN;
        end else begin
          y_step = y_q + Y_ONE;
        end
      end
      D_DN: begin
        if (y_q == '0) begin
          y_step   = Y_ONE;
          dir_step = D_UP;
        end else begin
          y_step = y_q - Y_ONE;
        end
      end
      default: begin
        y_step   = y_q;
        dir_step = D_STR;
      end
    endcase
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    step_d   = step_q;
    period_d = period_q;
    resp_d   = resp_q;
    hold_d   = hold_q;
    sa_d     = sa_q;
    sb_d     = sb_q;

    case (state_q)
      S_IDLE: begin
        // A wins a tie.
        if (edge_a) begin
          state_d = S_SERVE_A;
        end else if (edge_b) begin
          state_d = S_SERVE_B;
        end
      end

      S_SERVE_A: begin
        if (edge_a && (Y_in_A <= Y_TOP)) begin
          x_d     = '0;
          y_d     = Y_in_A;
          dir_d   = norm_dir(DIR_A);
          step_d  = '0;
          state_d = S_MOVE_B;
        end
      end

      S_SERVE_B: begin
        if (edge_b && (Y_in_B <= Y_TOP)) begin
          x_d     = X_END;
          y_d     = Y_in_B;
          dir_d   = norm_dir(DIR_B);
          step_d  = '0;
          state_d = S_MOVE_A;
        end
      end

      S_MOVE_B: begin
        if (step_due) begin
          step_d = '0;
          x_d    = x_q + X_ONE;
          y_d    = y_step;
          dir_d  = dir_step;
          if (x_q == X_PRE) begin
            resp_d  = '0;
            state_d = S_RESP_B;
          end
        end else begin
          step_d = step_q + ONE_P;
        end
      end

      S_MOVE_A: begin
        if (step_due) begin
          step_d = '0;
          x_d    = x_q - X_ONE;
          y_d    = y_step;
          dir_d  = dir_step;
          if (x_q == X_ONE) begin
            resp_d  = '0;
            state_d = S_RESP_A;
          end
        end else begin
          step_d = step_q + ONE_P;
        end
      end

      S_RESP_B: begin
        if (edge_b) begin
          if (Y_in_B == y_q) begin
            dir_d   = norm_dir(DIR_B);
            step_d  = '0;
            state_d = S_MOVE_A;
`ifdef HOCKEY_SPEEDUP_EN
            if (period_q > ONE_P) begin
              period_d = period_q - ONE_P;
            end
`endif
          end else begin
            sa_d     = (sa_q == WIN) ? sa_q : sa_q + SC_ONE;
            hold_d   = '0;
            period_d = STEP_P;
            state_d  = S_GOAL_A;
          end
        end else if (resp_q == RESP_LAST) begin
          sa_d     = (sa_q == WIN) ? sa_q : sa_q + SC_ONE;
          hold_d   = '0;
          period_d = STEP_P;
          state_d  = S_GOAL_A;
        end else begin
          resp_d = resp_q + 1'b1;
        end
      end

      S_RESP_A: begin
        if (edge_a) begin
          if (Y_in_A == y_q) begin
            dir_d   = norm_dir(DIR_A);
            step_d  = '0;
            state_d = S_MOVE_B;
`ifdef HOCKEY_SPEEDUP_EN
            if (period_q > ONE_P) begin
              period_d = period_q - ONE_P;
            end
`endif
          end else begin
            sb_d     = (sb_q == WIN) ? sb_q : sb_q + SC_ONE;
            hold_d   = '0;
            period_d = STEP_P;
            state_d  = S_GOAL_B;
          end
        end else if (resp_q == RESP_LAST) begin
          sb_d     = (sb_q == WIN) ? sb_q : sb_q + SC_ONE;
          hold_d   = '0;
          period_d = STEP_P;
          state_d  = S_GOAL_B;
        end else begin
          resp_d = resp_q + 1'b1;
        end
      end

      // The score was already bumped on entry, so the exit test sees the
      // updated value. The conceding player serves next.
      S_GOAL_A: begin
        if (hold_q == HOLD_LAST) begin
          state_d = (sa_q == WIN) ? S_OVER : S_SERVE_B;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      S_GOAL_B: begin
        if (hold_q == HOLD_LAST) begin
          state_d = (sb_q == WIN) ? S_OVER : S_SERVE_A;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      // Restart needs both players to press on the same cycle.
      S_OVER: begin
        if (edge_a && edge_b) begin
          sa_d    = '0;
          sb_d    = '0;
          x_d     = '0;
          y_d     = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_a_q  <= 1'b0;
      btn_b_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      dir_q    <= D_STR;
      step_q   <= '0;
      period_q <= STEP_P;
      resp_q   <= '0;
      hold_q   <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
    end else begin
      btn_a_q  <= BTN_A;
      btn_b_q  <= BTN_B;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      period_q <= period_d;
      resp_q   <= resp_d;
      hold_q   <= hold_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
    end
  end

  assign X_COORD    = x_q;
  assign Y_COORD    = y_q;
  assign SCORE_A    = sa_q;
  assign SCORE_B    = sb_q;
  assign GOAL_FLASH = (state_q == S_GOAL_A) || (state_q == S_GOAL_B);
  assign GAME_OVER  = (state_q == S_OVER);
  assign STATE      = state_q;

endmodule

// File: tb/tb_hockey_arena.sv
// Testbench for hockey_arena: directed game scenarios followed by random
// play, with every output compared each cycle against a game-level model.

module tb_hockey_arena;

  localparam int XW = 3, YW = 3, X_LAST = 4, Y_LAST = 4, SCORE_W = 3;
  localparam int WIN_SCORE = 3, STEP_CYC = 1, RESP_CYC = 8, HOLD_CYC = 2;

  // Debug STATE codes of the design.
  localparam int M_IDLE = 0, M_SERVE_A = 1, M_SERVE_B = 2, M_MOVE_A = 3;
  localparam int M_MOVE_B = 4, M_RESP_A = 5, M_RESP_B = 6, M_GOAL_A = 7;
  localparam int M_GOAL_B = 8, M_OVER = 9;

  logic               clk;
  logic               rst;
  logic               BTN_A, BTN_B;
  logic [1:0]         DIR_A, DIR_B;
  logic [YW-1:0]      Y_in_A, Y_in_B;
  logic [XW-1:0]      X_COORD;
  logic [YW-1:0]      Y_COORD;
  logic [SCORE_W-1:0] SCORE_A, SCORE_B;
  logic               GOAL_FLASH, GAME_OVER;
  logic [3:0]         STATE;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the game.
  int m_mode, m_x, m_y, m_dy, m_sa, m_sb, m_cnt, m_period;
  bit m_prev_a, m_prev_b;

  hockey_arena #(
    .XW(XW), .YW(YW), .X_LAST(X_LAST), .Y_LAST(Y_LAST), .SCORE_W(SCORE_W),
    .WIN_SCORE(WIN_SCORE), .STEP_CYC(STEP_CYC), .RESP_CYC(RESP_CYC),
    .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk(clk), .rst(rst), .BTN_A(BTN_A), .BTN_B(BTN_B),
    .DIR_A(DIR_A), .DIR_B(DIR_B), .Y_in_A(Y_in_A), .Y_in_B(Y_in_B),
    .X_COORD(X_COORD), .Y_COORD(Y_COORD), .SCORE_A(SCORE_A),
    .SCORE_B(SCORE_B), .GOAL_FLASH(GOAL_FLASH), .GAME_OVER(GAME_OVER),
    .STATE(STATE)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got,
                       input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int dir_to_dy(input logic [1:0] d);
    if (d == 2'b01) return 1;
    if (d == 2'b10) return -1;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_x = 0; m_y = 0; m_dy = 0; m_sa = 0; m_sb = 0;
    m_cnt = 0; m_period = STEP_CYC; m_prev_a = 0; m_prev_b = 0;
  endtask

  task automatic model_goal(input bit to_a);
    if (to_a) begin
      if (m_sa < WIN_SCORE) m_sa++;
      m_mode = M_GOAL_A;
    end else begin
      if (m_sb < WIN_SCORE) m_sb++;
      m_mode = M_GOAL_B;
    end
    m_cnt = 0;
    m_period = STEP_CYC;
  endtask

  task automatic model_return(input logic [1:0] d, input int next_mode);
    m_dy = dir_to_dy(d);
    m_cnt = 0;
    m_mode = next_mode;
`ifdef HOCKEY_SPEEDUP_EN
    if (m_period > 1) m_period--;
`endif
  endtask

  // One clock edge of game play, from the rules.
  task automatic model_step();
    bit ea, eb;
    int ny;
    if (!rst) begin
      model_reset();
      return;
    end
    ea = BTN_A && !m_prev_a;
    eb = BTN_B && !m_prev_b;
    m_prev_a = BTN_A;
    m_prev_b = BTN_B;
    case (m_mode)
      M_IDLE: begin
        if (ea) m_mode = M_SERVE_A;
        else if (eb) m_mode = M_SERVE_B;
      end
      M_SERVE_A: if (ea && Y_in_A <= Y_LAST) begin
        m_x = 0; m_y = Y_in_A; m_dy = dir_to_dy(DIR_A); m_cnt = 0;
        m_mode = M_MOVE_B;
      end
      M_SERVE_B: if (eb && Y_in_B <= Y_LAST) begin
        m_x = X_LAST; m_y = Y_in_B; m_dy = dir_to_dy(DIR_B); m_cnt = 0;
        m_mode = M_MOVE_A;
      end
      M_MOVE_A, M_MOVE_B: begin
        m_cnt++;
        if (m_cnt == m_period) begin
          m_cnt = 0;
          m_x += (m_mode == M_MOVE_B) ? 1 : -1;
          ny = m_y + m_dy;
          if (ny > Y_LAST) begin ny = Y_LAST - 1; m_dy = -1; end
          else if (ny < 0) begin ny = 1; m_dy = 1; end
          m_y = ny;
          if (m_mode == M_MOVE_B && m_x == X_LAST) m_mode = M_RESP_B;
          else if (m_mode == M_MOVE_A && m_x == 0) m_mode = M_RESP_A;
        end
      end
      M_RESP_B: begin
        if (eb) begin
          if (Y_in_B == m_y) model_return(DIR_B, M_MOVE_A);
          else model_goal(1);
        end else begin
          m_cnt++;
          if (m_cnt == RESP_CYC) model_goal(1);
        end
      end
      M_RESP_A: begin
        if (ea) begin
          if (Y_in_A == m_y) model_return(DIR_A, M_MOVE_B);
          else model_goal(0);
        end else begin
          m_cnt++;
          if (m_cnt == RESP_CYC) model_goal(0);
        end
      end
      M_GOAL_A, M_GOAL_B: begin
        m_cnt++;
        if (m_cnt == HOLD_CYC) begin
          if (m_mode == M_GOAL_A) m_mode = (m_sa == WIN_SCORE) ? M_OVER : M_SERVE_B;
          else m_mode = (m_sb == WIN_SCORE) ? M_OVER : M_SERVE_A;
        end
      end
      M_OVER: if (ea && eb) begin
        m_sa = 0; m_sb = 0; m_x = 0; m_y = 0; m_mode = M_IDLE;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  // ---------------- scoreboard ----------------
  task automatic compare_all();
    check("x", X_COORD, m_x);
    check("y", Y_COORD, m_y);
    check("score_a", SCORE_A, m_sa);
    check("score_b", SCORE_B, m_sb);
    check("goal_flash", GOAL_FLASH, (m_mode == M_GOAL_A || m_mode == M_GOAL_B));
    check("game_over", GAME_OVER, (m_mode == M_OVER));
    check("state", STATE, m_mode);
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock: the model takes the edge, outputs are sampled on the
  // falling edge, and the caller then drives the next inputs.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic press_a(input int y, input logic [1:0] d);
    Y_in_A = YW'(y); DIR_A = d; BTN_A = 1'b1;
    tick();
    BTN_A = 1'b0;
    tick();
  endtask

  task automatic press_b(input int y, input logic [1:0] d);
    Y_in_B = YW'(y); DIR_B = d; BTN_B = 1'b1;
    tick();
    BTN_B = 1'b0;
    tick();
  endtask

  // Bounded wait for the game to reach a state; an expired budget shows up
  // as a failed state comparison.
  task automatic run_until(input int code, input int budget, input string tag);
    int n = 0;
    while (m_mode != code && n < budget) begin
      tick();
      n++;
    end
    check(tag, STATE, code);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_y[4] = '{3, 4, 3, 2};
    int n;

    rst = 1'b0; BTN_A = 0; BTN_B = 0; DIR_A = 0; DIR_B = 0;
    Y_in_A = 0; Y_in_B = 0;
    model_reset();

    // Reset state.
    #1;
    check("rst_x", X_COORD, 0);
    check("rst_y", Y_COORD, 0);
    check("rst_score_a", SCORE_A, 0);
    check("rst_score_b", SCORE_B, 0);
    check("rst_flash", GOAL_FLASH, 0);
    check("rst_over", GAME_OVER, 0);
    check("rst_state", STATE, M_IDLE);
    tick(); tick();
    rst = 1'b1;

    // Serve and miss.
    press_a(0, 2'b00);
    check("idle_to_serve_a", STATE, M_SERVE_A);
    press_a(2, 2'b00);
    run_until(M_RESP_B, 20, "serve_reach_b");
    check("serve_x_end", X_COORD, 4);
    check("serve_y", Y_COORD, 2);
    press_b(3, 2'b00);
    run_until(M_SERVE_B, 10, "miss_to_serve_b");
    check("miss_score_a", SCORE_A, 1);

    // Bounce return.
    press_b(2, 2'b00);
    run_until(M_RESP_A, 20, "serve_b_reach_a");
    Y_in_A = 2; DIR_A = 2'b01; BTN_A = 1'b1;
    tick();
    BTN_A = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bounce_x", X_COORD, i + 1);
      check("bounce_y", Y_COORD, exp_y[i]);
    end
    check("bounce_resp_b", STATE, M_RESP_B);

    // Timeout.
    press_b(2, 2'b00);
    run_until(M_RESP_A, 20, "return_reach_a");
    repeat (RESP_CYC) tick();
    check("timeout_goal_b", STATE, M_GOAL_B);
    run_until(M_SERVE_A, 10, "timeout_to_serve_a");
    check("timeout_score_b", SCORE_B, 1);

    // Held button serves once, and still held at arrival is no hit.
    Y_in_A = 1; DIR_A = 2'b00; BTN_A = 1'b1;
    repeat (5) tick();
    check("held_serve_x", X_COORD, 4);
    check("held_serve_state", STATE, M_RESP_B);
    Y_in_B = 1; DIR_B = 2'b00; BTN_B = 1'b1;
    tick();
    BTN_B = 1'b0;
    run_until(M_RESP_A, 20, "held_reach_a");
    repeat (RESP_CYC) tick();
    check("held_no_hit", STATE, M_GOAL_B);
    BTN_A = 1'b0;
    run_until(M_SERVE_A, 10, "held_to_serve_a");
    check("held_score_b", SCORE_B, 2);

    // Invalid serve row.
    press_a(6, 2'b00);
    check("invalid_row_ignored", STATE, M_SERVE_A);
    press_a(7, 2'b01);
    check("invalid_row7_ignored", STATE, M_SERVE_A);

    // Play A up to the win: A returns, B misses.
    n = 0;
    while (m_mode != M_OVER && n < 400) begin
      case (m_mode)
        M_SERVE_A: press_a(0, 2'b00);
        M_SERVE_B: press_b(0, 2'b00);
        M_RESP_A:  press_a(m_y, 2'b00);
        M_RESP_B:  press_b((m_y + 1) % 8, 2'b00);
        default:   tick();
      endcase
      n++;
    end
    check("win_game_over", GAME_OVER, 1);
    check("win_score_a", SCORE_A, 3);
    press_a(0, 2'b00);
    press_b(0, 2'b00);
    check("over_single_ignored", STATE, M_OVER);
    BTN_A = 1'b1; BTN_B = 1'b1;
    tick();
    BTN_A = 1'b0; BTN_B = 1'b0;
    tick();
    check("restart_state", STATE, M_IDLE);
    check("restart_score_a", SCORE_A, 0);
    check("restart_score_b", SCORE_B, 0);

    // Asynchronous reset in the middle of a move.
    press_a(0, 2'b00);
    press_a(3, 2'b10);
    check("pre_reset_move", STATE, M_MOVE_B);
    #2 rst = 1'b0;
    #1;
    check("async_x", X_COORD, 0);
    check("async_y", Y_COORD, 0);
    check("async_state", STATE, M_IDLE);
    check("async_score_a", SCORE_A, 0);
    check("async_flash", GOAL_FLASH, 0);
    tick();
    rst = 1'b1;
    repeat (3) tick();
    check("post_reset_idle", STATE, M_IDLE);

    // Random play.
    for (int c = 0; c < 3000; c++) begin
      BTN_A = ($urandom_range(0, 2) == 0);
      BTN_B = ($urandom_range(0, 2) == 0);
      DIR_A = 2'($urandom_range(0, 3));
      DIR_B = 2'($urandom_range(0, 3));
      Y_in_A = ($urandom_range(0, 1) == 0) ? YW'(m_y) : YW'($urandom_range(0, 7));
      Y_in_B = ($urandom_range(0, 1) == 0) ? YW'(m_y) : YW'($urandom_range(0, 7));
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
